ir_remote_frontend: RTL and testbench

Front end of the Samsung IR remote transmitter. It turns the active-low push-buttons into 32-bit Samsung command words and generates the 38 kHz carrier from the 50 MHz system clock. It also gates that carrier with the external protocol modulation signal to drive the IR LED. It sits between the board buttons/LED and the Samsung frame serializer, which consumes `command`/`cmd_valid` and returns `ir_mod`.

---
 rtl/ir_remote_pkg.sv | 24 ++
 rtl/ir_carrier_gen.sv | 33 +++
 rtl/ir_remote_frontend.sv | 139 +++++++++++++
 tb/tb_ir_remote_frontend.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_remote_pkg.sv
// rtl/ir_remote_pkg.sv - shared constants and helpers for the IR remote front end
//
// Contents:
//   CODE_*      32-bit Samsung command words, one per push-button
//   KEY_*       bit index of each function within the KEY bus
//   calc_half() carrier half-period in system clock cycles, rounded to nearest
package ir_remote_pkg;

  localparam logic [31:0] CODE_POWER = 32'hE0E0_40BF;
  localparam logic [31:0] CODE_VOLUP = 32'hE0E0_E01F;
  localparam logic [31:0] CODE_VOLDN = 32'hE0E0_D02F;
  localparam logic [31:0] CODE_MUTE  = 32'hE0E0_F00F;

  localparam int KEY_POWER = 3;
  localparam int KEY_VOLUP = 2;
  localparam int KEY_VOLDN = 1;
  localparam int KEY_MUTE  = 0;

  // Adding CARRIER_HZ before dividing by 2*CARRIER_HZ rounds to nearest.
  function automatic int calc_half(input int clk_hz, input int carrier_hz);
    return (clk_hz + carrier_hz) / (2 * carrier_hz);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - square-wave IR carrier derived from the system clock
//
// Parameters:
//   HALF    carrier half-period in clk cycles
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   clk_38  carrier output, toggles every HALF cycles (data signal, not a clock)
module ir_carrier_gen #(
  parameter int HALF = 658
) (
  input  logic clk,
  input  logic reset,
  output logic clk_38
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      clk_38 <= 1'b0;
    end else if (cnt == CW'(HALF - 1)) begin
      cnt    <= '0;
      clk_38 <= ~clk_38;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_remote_frontend.sv
// rtl/ir_remote_frontend.sv - push-button to Samsung command mapping, carrier and LED gating
//
// Optional feature: define KEY_DEBOUNCE_EN to add a per-key stable-level debouncer.
// Parameters:
//   CLK_HZ, CARRIER_HZ  set the carrier half-period
//   DEBOUNCE_CYCLES     stable cycles needed before a key level is accepted
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   KEY        active-low push-buttons, asynchronous to clk
//   ir_mod     burst envelope from the frame serializer
//   command    most recently pressed key's code
//   cmd_valid  one-cycle strobe when command is loaded
//   clk_38     carrier
//   IR_LED     registered ir_mod & clk_38
module ir_remote_frontend
  import ir_remote_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int CARRIER_HZ      = 38_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  KEY,
  input  logic        ir_mod,
  output logic [31:0] command,
  output logic        cmd_valid,
  output logic        clk_38,
  output logic        IR_LED
);

  localparam int HALF = calc_half(CLK_HZ, CARRIER_HZ);

  if (DEBOUNCE_CYCLES < 1 || CARRIER_HZ < 1) begin : g_bad_cfg
    $error("ir_remote_frontend: DEBOUNCE_CYCLES and CARRIER_HZ must be positive");
  end

  ir_carrier_gen #(
    .HALF(HALF)
  ) u_carrier (
    .clk   (clk),
    .reset (reset),
    .clk_38(clk_38)
  );

  // Two-stage synchronizer; released (1) out of reset so no false press.
  logic [3:0] key_meta;
  logic [3:0] key_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 4'hF;
      key_sync <= 4'hF;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
    end
  end

  logic [3:0] key_level;

`ifdef KEY_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic          deb_q;
    logic [DW-1:0] deb_cnt;

    // Count consecutive cycles the synchronized level differs from the
    // accepted one; any return to the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_q   <= 1'b1;
        deb_cnt <= '0;
      end else if (key_sync[i] == deb_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q   <= key_sync[i];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end

    assign key_level[i] = deb_q;
  end
`else
  assign key_level = key_sync;
`endif

  logic [3:0] key_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= 4'hF;
    end else begin
      key_prev <= key_level;
    end
  end

  // Falling edge only: held keys and releases produce nothing.
  logic [3:0] key_press;
  assign key_press = key_prev & ~key_level;

  logic [31:0] code_sel;

  always_comb begin
    code_sel = CODE_MUTE;
    if (key_press[KEY_POWER]) begin
      code_sel = CODE_POWER;
    end else if (key_press[KEY_VOLUP]) begin
      code_sel = CODE_VOLUP;
    end else if (key_press[KEY_VOLDN]) begin
      code_sel = CODE_VOLDN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      command   <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= |key_press;
      if (|key_press) begin
        command <= code_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR_LED <= 1'b0;
    end else begin
      IR_LED <= ir_mod & clk_38;
    end
  end

endmodule

// File: tb/tb_ir_remote_frontend.sv
// tb/tb_ir_remote_frontend.sv - randomized self-checking bench for ir_remote_frontend
module tb_ir_remote_frontend;

  localparam int HALF = 658;
  localparam int DEB  = 8;
  localparam int QLEN = DEB + 4;

`ifdef KEY_DEBOUNCE_EN
  localparam int HOLD = 12;
  localparam int GLITCH_PULSES = 0;
`else
  localparam int HOLD = 2;
  localparam int GLITCH_PULSES = 1;
`endif
  localparam int SETTLE = DEB + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic        ir_mod = 1'b0;
  logic [31:0] command;
  logic        cmd_valid;
  logic        clk_38;
  logic        IR_LED;

  ir_remote_frontend #(
    .CLK_HZ         (50_000_000),
    .CARRIER_HZ     (38_000),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .KEY      (KEY),
    .ir_mod   (ir_mod),
    .command  (command),
    .cmd_valid(cmd_valid),
    .clk_38   (clk_38),
    .IR_LED   (IR_LED)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: key samples and the detector's accepted level, newest first.
  logic [3:0]  ksq[$];
  logic [3:0]  lvq[$];
  int          t;
  logic [31:0] exp_cmd;
  logic        clk_prev;

  function automatic logic [31:0] code_of(input logic [3:0] p);
    if (p[3]) return 32'hE0E040BF;
    if (p[2]) return 32'hE0E0E01F;
    if (p[1]) return 32'hE0E0D02F;
    return 32'hE0E0F00F;
  endfunction

  task automatic model_reset();
    ksq = {};
    lvq = {};
    for (int i = 0; i < QLEN; i++) begin
      ksq.push_front(4'hF);
      lvq.push_front(4'hF);
    end
    t        = 0;
    exp_cmd  = '0;
    clk_prev = 1'b0;
  endtask

  // Apply inputs, advance one edge, check all outputs against the model.
  task automatic step(input logic [3:0] k, input logic m, output logic pulse);
    logic [3:0] lv;
    logic [3:0] pressed;
    logic       exp_clk;
    logic       all_diff;
    KEY    = k;
    ir_mod = m;
    @(posedge clk);
    #1;
    t++;
    ksq.push_front(k);
`ifdef KEY_DEBOUNCE_EN
    // Accept a new level once the synchronized key (2 edges late) has
    // shown it for DEB consecutive edges.
    lv = lvq[0];
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) begin
        if (ksq[2 + i][b] == lvq[0][b]) all_diff = 1'b0;
      end
      if (all_diff) lv[b] = ~lvq[0][b];
    end
`else
    lv = ksq[1];
`endif
    lvq.push_front(lv);
    pressed = lvq[2] & ~lvq[1];
    if (|pressed) exp_cmd = code_of(pressed);
    exp_clk = ((t / HALF) % 2) == 1;
    chk("cmd_valid", 32'(cmd_valid), 32'(|pressed));
    chk("command", command, exp_cmd);
    chk("clk_38", 32'(clk_38), 32'(exp_clk));
    chk("IR_LED", 32'(IR_LED), 32'(m & clk_prev));
    clk_prev = exp_clk;
    pulse    = cmd_valid;
    while (ksq.size() > QLEN) void'(ksq.pop_back());
    while (lvq.size() > QLEN) void'(lvq.pop_back());
  endtask

  task automatic press_seq(input logic [3:0] k, input int hold, output int pulses);
    logic p;
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      step(k, 1'b0, p);
      pulses += int'(p);
    end
    for (int i = 0; i < SETTLE; i++) begin
      step(4'hF, 1'b0, p);
      pulses += int'(p);
    end
  endtask

  task automatic run_random(input int segments);
    logic [3:0] k;
    logic       m;
    logic       p;
    int         len;
    for (int s = 0; s < segments; s++) begin
      k   = 4'($urandom);
      m   = 1'($urandom);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step(k, m, p);
    end
  endtask

  initial begin
    int   pulses;
    int   led_ones;
    logic p;

    #2;
    chk("rst_command", command, 32'h0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_clk_38", 32'(clk_38), 32'h0);
    chk("rst_IR_LED", 32'(IR_LED), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 3; i++) step(4'hF, 1'b0, p);

    press_seq(4'b0111, HOLD, pulses);
    chk("power_pulses", 32'(pulses), 32'd1);
    chk("power_code", command, 32'hE0E040BF);

    press_seq(4'b1010, HOLD, pulses);
    chk("prio_pulses", 32'(pulses), 32'd1);
    chk("prio_code", command, 32'hE0E0E01F);

    pulses = 0;
    for (int i = 0; i < SETTLE; i++) begin
      step(4'b1101, 1'b0, p);
      pulses += int'(p);
    end
    chk("held_first_code", command, 32'hE0E0D02F);
    for (int i = 0; i < SETTLE; i++) begin
      step(4'b1100, 1'b0, p);
      pulses += int'(p);
    end
    for (int i = 0; i < SETTLE; i++) begin
      step(4'hF, 1'b0, p);
      pulses += int'(p);
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_second_code", command, 32'hE0E0F00F);

    press_seq(4'b1110, 5, pulses);
    chk("glitch_pulses", 32'(pulses), 32'(GLITCH_PULSES));

    led_ones = 0;
    for (int i = 0; i < 2 * HALF + 10; i++) begin
      step(4'hF, 1'b0, p);
      led_ones += int'(IR_LED);
    end
    chk("led_off_ones", 32'(led_ones), 32'd0);
    for (int i = 0; i < 2 * HALF + 10; i++) step(4'hF, 1'b1, p);

    run_random(250);

    #2;
    reset = 1'b1;
    KEY   = 4'hF;
    #1;
    chk("mid_rst_command", command, 32'h0);
    chk("mid_rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("mid_rst_clk_38", 32'(clk_38), 32'h0);
    chk("mid_rst_IR_LED", 32'(IR_LED), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 2 * HALF + 10; i++) step(4'hF, 1'b1, p);
    run_random(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
